macro_slot_ctrl: RTL and testbench



---
 rtl/macro_slot_ctrl.sv | 173 +++++++++++++++++
 tb/tb_macro_slot_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/macro_slot_ctrl.sv
// rtl/macro_slot_ctrl.sv - Wishbone slot controller routing user-area transfers to experiment macros
// Timeout counter, irq_o and STATUS are built only when MACRO_CTRL_TIMEOUT_EN is defined.
module macro_slot_ctrl #(
  parameter int NUM_SLOTS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    wbs_stb_i,
  input  logic                    wbs_cyc_i,
  input  logic                    wbs_we_i,
  input  logic [3:0]              wbs_sel_i,
  input  logic [31:0]             wbs_adr_i,
  input  logic [31:0]             wbs_dat_i,
  output logic                    wbs_ack_o,
  output logic [31:0]             wbs_dat_o,
  input  logic [NUM_SLOTS-1:0]    active_i,
  output logic [NUM_SLOTS-1:0]    s_cyc_o,
  output logic [NUM_SLOTS-1:0]    s_stb_o,
  output logic                    s_we_o,
  output logic [3:0]              s_sel_o,
  output logic [31:0]             s_adr_o,
  output logic [31:0]             s_dat_o,
  input  logic [NUM_SLOTS-1:0]    s_ack_i,
  input  logic [32*NUM_SLOTS-1:0] s_dat_i,
  output logic [NUM_SLOTS-1:0]    io_sel_o,
  output logic                    irq_o
);

  typedef enum logic [2:0] {IDLE, FWD, LOCAL, ERR, RESP} state_t;

  localparam logic [4:0] NUM_SLOTS_W = NUM_SLOTS[4:0];

  state_t      state, state_nx;
  logic [3:0]  slot_q;
  logic [3:0]  io_owner;
  logic [3:0]  req_slot;
  logic [15:0] active_ext;
  logic [15:0] ack_ext;
  logic        req_window, req_fwd, req_local;
  logic        slot_ack, timed_out;
  logic [31:0] slot_rdata, local_rdata, status_word;

  assign active_ext = 16'(active_i);
  assign ack_ext    = 16'(s_ack_i);
  assign req_slot   = wbs_adr_i[23:20];
  assign req_window = (wbs_adr_i[31:24] == 8'h30);
  assign req_local  = req_window && (req_slot == 4'hF);
  assign req_fwd    = req_window && ({1'b0, req_slot} < NUM_SLOTS_W) && active_ext[req_slot];
  assign slot_ack   = ack_ext[slot_q];

`ifdef MACRO_CTRL_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] to_cnt;
  logic [7:0] to_count;
  logic [3:0] last_to_slot;
  logic       irq_q;

  // to_cnt holds the number of completed FWD cycles, so the strobe lives exactly TIMEOUT cycles
  assign timed_out   = (to_cnt == TO_LAST);
  assign status_word = {irq_q, 3'b0, last_to_slot, 16'b0, to_count};
  assign irq_o       = irq_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      to_cnt       <= '0;
      to_count     <= '0;
      last_to_slot <= '0;
      irq_q        <= 1'b0;
    end else begin
      to_cnt <= (state == FWD) ? to_cnt + 8'd1 : 8'd0;
      if (state == FWD && state_nx == ERR) begin
        irq_q        <= 1'b1;
        last_to_slot <= slot_q;
        if (to_count != 8'hFF) to_count <= to_count + 8'd1;
      end else if (state == LOCAL && s_we_o && s_adr_o[3:0] == 4'h4 && s_dat_o[31]) begin
        irq_q    <= 1'b0;
        to_count <= '0;
      end
    end
  end
`else
  assign timed_out   = 1'b0;
  assign status_word = '0;
  assign irq_o       = 1'b0;
`endif

  always_comb begin
    slot_rdata = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (slot_q == 4'(k)) slot_rdata = s_dat_i[32*k +: 32];
    end
  end

  always_comb begin
    local_rdata = '0;
    case (s_adr_o[3:0])
      4'h0:    local_rdata = {28'b0, io_owner};
      4'h4:    local_rdata = status_word;
      default: local_rdata = '0;
    endcase
  end

  always_comb begin
    io_sel_o = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      io_sel_o[k] = (io_owner == 4'(k)) && active_i[k];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    s_cyc_o  = '0;
    s_stb_o  = '0;
    case (state)
      IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) state_nx = req_fwd ? FWD : (req_local ? LOCAL : ERR);
      end
      FWD: begin
        for (int k = 0; k < NUM_SLOTS; k++) begin
          s_cyc_o[k] = (slot_q == 4'(k));
          s_stb_o[k] = (slot_q == 4'(k));
        end
        // abort beats a late slave ack; an ack on the terminal count beats the timeout
        if (!wbs_cyc_i)     state_nx = IDLE;
        else if (slot_ack)  state_nx = RESP;
        else if (timed_out) state_nx = ERR;
      end
      LOCAL:   state_nx = RESP;
      ERR:     state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      slot_q    <= '0;
      io_owner  <= '0;
      s_we_o    <= 1'b0;
      s_sel_o   <= '0;
      s_adr_o   <= '0;
      s_dat_o   <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= (state_nx == RESP);
      if (state == IDLE && wbs_cyc_i && wbs_stb_i) begin
        slot_q  <= req_slot;
        s_we_o  <= wbs_we_i;
        s_sel_o <= wbs_sel_i;
        s_adr_o <= wbs_adr_i;
        s_dat_o <= wbs_dat_i;
      end
      case (state)
        FWD: if (state_nx == RESP) wbs_dat_o <= slot_rdata;
        LOCAL: begin
          wbs_dat_o <= local_rdata;
          if (s_we_o && s_adr_o[3:0] == 4'h0 && s_sel_o[0]) io_owner <= s_dat_o[3:0];
        end
        ERR:     wbs_dat_o <= 32'hDEAD_DEAD;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_macro_slot_ctrl.sv
// tb/tb_macro_slot_ctrl.sv - randomized and directed bench for macro_slot_ctrl against a transaction-level model
module tb_macro_slot_ctrl;
  localparam int NS = 4;
  localparam int TO = 8;
`ifdef MACRO_CTRL_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0] wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [NS-1:0] active_i, s_cyc_o, s_stb_o, s_ack_i, io_sel_o;
  logic s_we_o, irq_o;
  logic [3:0] s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [32*NS-1:0] s_dat_i;

  int total = 0;
  int bad = 0;

  // transaction model state
  logic [3:0] m_owner;
  logic       m_irq;
  logic [7:0] m_cnt;
  logic [3:0] m_last;

  // results of the last bus transfer
  logic [31:0]   r_rdata;
  int            r_lat, r_nstb;
  logic [NS-1:0] r_mask;
  bit            r_acked, r_double, r_req_ok;

  always #5 clk = ~clk;

  macro_slot_ctrl #(.NUM_SLOTS(NS), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .active_i(active_i), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .io_sel_o(io_sel_o), .irq_o(irq_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [NS-1:0] exp_io();
    int o;
    o = int'(m_owner);
    exp_io = '0;
    if (o < NS && active_i[o]) exp_io[o] = 1'b1;
  endfunction

  task automatic model_reset();
    m_owner = '0;
    m_irq   = 1'b0;
    m_cnt   = '0;
    m_last  = '0;
  endtask

  // one master transfer; the slave acks on its ack_at-th strobe cycle (0 = never)
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input int ack_at, input logic [31:0] sdat);
    @(negedge clk);
    wbs_adr_i = a; wbs_we_i = w; wbs_dat_i = d; wbs_sel_i = s;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
    for (int k = 0; k < NS; k++) s_dat_i[32*k +: 32] = $urandom;
    r_lat = 0; r_nstb = 0; r_mask = '0; r_acked = 0; r_double = 0; r_req_ok = 1; r_rdata = '0;
    for (int n = 1; n <= 400 && !r_acked; n++) begin
      @(negedge clk);
      s_ack_i = '0;
      if (s_stb_o != '0) begin
        r_nstb++;
        r_mask |= s_stb_o;
        if (s_cyc_o !== s_stb_o || s_adr_o !== a || s_we_o !== w || s_dat_o !== d || s_sel_o !== s)
          r_req_ok = 0;
        if (r_nstb == ack_at) begin
          for (int k = 0; k < NS; k++) begin
            if (s_stb_o[k]) begin
              s_ack_i[k] = 1'b1;
              s_dat_i[32*k +: 32] = sdat;
            end
          end
        end
      end
      if (wbs_ack_o) begin
        r_acked = 1; r_lat = n; r_rdata = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      end
    end
    @(negedge clk);
    r_double = wbs_ack_o;
    s_ack_i = '0;
  endtask

  // predict the outcome from the address map and slave behaviour, run it, compare, update the model
  task automatic run(input string tag, input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, input int ack_at, input logic [31:0] sdat);
    int slot, off, kind, e_lat, e_nstb;
    bit to;
    logic [31:0] e_rd, status;
    logic [NS-1:0] e_mask;
    slot = int'(a[23:20]);
    off  = int'(a[3:0]);
    status = TEN ? {m_irq, 3'b0, m_last, 16'b0, m_cnt} : 32'h0;
    if (a[31:24] != 8'h30) kind = 0;
    else if (slot == 15) kind = 2;
    else if (slot < NS && active_i[slot] === 1'b1) kind = 1;
    else kind = 0;
    to = TEN && (ack_at < 1 || ack_at > TO);
    e_rd = 32'hDEAD_DEAD; e_lat = 2; e_nstb = 0; e_mask = '0;
    if (kind == 2) begin
      e_rd = (off == 0) ? {28'b0, m_owner} : ((off == 4) ? status : 32'h0);
    end else if (kind == 1) begin
      e_mask[slot] = 1'b1;
      if (to) begin
        e_lat = TO + 2; e_nstb = TO;
      end else begin
        e_rd = sdat; e_lat = ack_at + 1; e_nstb = ack_at;
      end
    end
    xfer(a, w, d, s, ack_at, sdat);
    if (kind == 2 && w) begin
      if (off == 0 && s[0]) m_owner = d[3:0];
      if (off == 4 && d[31]) begin m_irq = 1'b0; m_cnt = '0; end
    end
    if (kind == 1 && to) begin
      m_irq = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      m_last = a[23:20];
    end
    check({tag, ".acked"}, 32'(r_acked), 32'd1);
    check({tag, ".lat"}, 32'(r_lat), 32'(e_lat));
    check({tag, ".nstb"}, 32'(r_nstb), 32'(e_nstb));
    check({tag, ".mask"}, 32'(r_mask), 32'(e_mask));
    check({tag, ".req"}, 32'(r_req_ok), 32'd1);
    check({tag, ".single_ack"}, 32'(r_double), 32'd0);
    if (!w) check({tag, ".rdata"}, r_rdata, e_rd);
    check({tag, ".irq"}, 32'(irq_o), 32'(m_irq));
    check({tag, ".io_sel"}, 32'(io_sel_o), 32'(exp_io()));
  endtask

  initial begin
    int acks;
    logic [31:0] a;
    rst = 1'b1;
    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    active_i = '0; s_ack_i = '0; s_dat_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst.ack", 32'(wbs_ack_o), 32'd0);
    check("rst.dat", wbs_dat_o, 32'd0);
    check("rst.cyc", 32'(s_cyc_o), 32'd0);
    check("rst.stb", 32'(s_stb_o), 32'd0);
    check("rst.adr", s_adr_o, 32'd0);
    check("rst.wdat", s_dat_o, 32'd0);
    check("rst.we_sel", {27'd0, s_we_o, s_sel_o}, 32'd0);
    check("rst.irq", 32'(irq_o), 32'd0);
    rst = 1'b0;

    // forwarded read, slot 1 acks on its third strobe cycle
    active_i = 4'b0010;
    run("fwd1", 32'h3010_0000, 1'b0, 32'h0, 4'hF, 3, 32'h1234_5678);
    check("fwd1.lit", r_rdata, 32'h1234_5678);

    // pad owner register
    active_i = 4'b0100;
    run("own_wr", 32'h30F0_0000, 1'b1, 32'h2, 4'h1, 0, 32'h0);
    run("own_rd", 32'h30F0_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0);
    check("own.lit", r_rdata, 32'h2);
    check("own.io_on", 32'(io_sel_o), 32'h4);
    active_i = 4'b0000;
    #1 check("own.io_off", 32'(io_sel_o), 32'h0);
    run("own_nosel", 32'h30F0_0000, 1'b1, 32'h1, 4'h2, 0, 32'h0);

    // inactive and out-of-range slots
    active_i = 4'b0111;
    run("err_inact", 32'h3030_0000, 1'b0, 32'h0, 4'hF, 1, 32'h1);
    run("err_range", 32'h3050_0000, 1'b0, 32'h0, 4'hF, 1, 32'h1);
    run("err_win", 32'h3110_0000, 1'b0, 32'h0, 4'hF, 1, 32'h1);

`ifdef MACRO_CTRL_TIMEOUT_EN
    active_i = 4'b0001;
    run("to", 32'h3000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0);
    run("to_st", 32'h30F0_0004, 1'b0, 32'h0, 4'hF, 0, 32'h0);
    check("to_st.lit", r_rdata, 32'h8000_0001);
    run("to_clr", 32'h30F0_0004, 1'b1, 32'h8000_0000, 4'hF, 0, 32'h0);
    check("to_clr.irq", 32'(irq_o), 32'd0);
    run("to_st0", 32'h30F0_0004, 1'b0, 32'h0, 4'hF, 0, 32'h0);
    run("to_edge", 32'h3000_0000, 1'b0, 32'h0, 4'hF, TO, 32'hCAFE_0008);
    run("to_past", 32'h3000_0000, 1'b0, 32'h0, 4'hF, TO + 1, 32'hCAFE_0009);
`endif

    // master abort during forwarding
    active_i = 4'b0010;
    @(negedge clk);
    wbs_adr_i = 32'h3010_0000; wbs_we_i = 0; wbs_cyc_i = 1; wbs_stb_i = 1;
    @(negedge clk);
    check("abort.stb_on", 32'(s_stb_o), 32'h2);
    @(negedge clk);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    acks = 0;
    @(negedge clk);
    check("abort.stb_off", 32'(s_stb_o), 32'h0);
    if (wbs_ack_o) acks++;
    repeat (4) begin
      @(negedge clk);
      if (wbs_ack_o) acks++;
    end
    check("abort.no_ack", 32'(acks), 32'd0);

    // request held through RESP is taken only in the following idle cycle
    @(negedge clk);
    wbs_adr_i = 32'h30F0_0000; wbs_we_i = 0; wbs_cyc_i = 1; wbs_stb_i = 1;
    @(negedge clk);
    @(negedge clk);
    check("b2b.ack1", 32'(wbs_ack_o), 32'd1);
    wbs_adr_i = 32'h3050_0000;
    @(negedge clk);
    check("b2b.gap", 32'(wbs_ack_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("b2b.ack2", 32'(wbs_ack_o), 32'd1);
    check("b2b.dat2", wbs_dat_o, 32'hDEAD_DEAD);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(negedge clk);

    // randomized mix of local, forwarded and error transfers
    for (int i = 0; i < 40; i++) begin
      int slot, ack_at;
      logic [3:0] off;
      active_i = NS'($urandom);
      slot = ($urandom_range(0, 3) == 0) ? 15 : $urandom_range(0, 5);
      case ($urandom_range(0, 2))
        0:       off = 4'h0;
        1:       off = 4'h4;
        default: off = 4'h8;
      endcase
      a = {(($urandom_range(0, 7) == 0) ? 8'h31 : 8'h30), 4'(slot), 16'($urandom), off};
`ifdef MACRO_CTRL_TIMEOUT_EN
      ack_at = $urandom_range(0, 10);
`else
      ack_at = $urandom_range(1, 10);
`endif
      run($sformatf("rnd%0d", i), a, 1'($urandom), $urandom, 4'($urandom), ack_at, $urandom);
    end

    // very slow slave
    active_i = 4'b0010;
    run("slow", 32'h3010_0000, 1'b0, 32'h0, 4'hF, 300, 32'h5A5A_0300);

    // asynchronous reset in the middle of a forwarded transfer
    run("pre_rst", 32'h30F0_0000, 1'b1, 32'h1, 4'h1, 0, 32'h0);
    check("pre_rst.io", 32'(io_sel_o), 32'h2);
    @(negedge clk);
    wbs_adr_i = 32'h3010_0000; wbs_we_i = 1; wbs_dat_i = 32'h77; wbs_sel_i = 4'hF;
    wbs_cyc_i = 1; wbs_stb_i = 1;
    @(negedge clk);
    check("mid.stb_on", 32'(s_stb_o), 32'h2);
    #2 rst = 1'b1;
    #1;
    check("mid.stb", 32'(s_stb_o), 32'h0);
    check("mid.cyc", 32'(s_cyc_o), 32'h0);
    check("mid.adr", s_adr_o, 32'h0);
    check("mid.wdat", s_dat_o, 32'h0);
    check("mid.we_sel", {27'd0, s_we_o, s_sel_o}, 32'd0);
    check("mid.ack", 32'(wbs_ack_o), 32'd0);
    check("mid.dat", wbs_dat_o, 32'h0);
    check("mid.io", 32'(io_sel_o), 32'h0);
    check("mid.irq", 32'(irq_o), 32'd0);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run("post_rst", 32'h30F0_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
